// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result select, load size, FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_DWORD = 2'd3
  } load_size_e;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2
  } state_e;

  localparam int ZERO_REG_DEFAULT = 31;

endpackage

// File: rtl/load_extend.sv
// Load aligner/extender: shifts the read data down to the addressed byte lane, keeps
// 8/16/32/64 bits and sign/zero-extends; purely combinational, no handshake.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]          i_rdata,
  input  logic [1:0]                 i_size,
  input  logic                       i_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0] i_off,
  output logic [DATA_W-1:0]          o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic              w_sign;
  int                w_keep;

  // Lanes above the top byte fill with zeros, so misaligned loads never wrap.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    w_keep = DATA_W;
    o_data = '0;
    case (i_size)
      LS_BYTE: begin w_keep = 8;      w_sign = w_shifted[7];        end
      LS_HALF: begin w_keep = 16;     w_sign = w_shifted[15];       end
      LS_WORD: begin w_keep = 32;     w_sign = w_shifted[31];       end
      default: begin w_keep = DATA_W; w_sign = w_shifted[DATA_W-1]; end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      o_data[i] = (i < w_keep) ? w_shifted[i] : (w_sign & ~i_unsigned);
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: one instruction in flight; rf write 1 cycle after accept (non-load) or
// 1 cycle after dmem_rvalid (load). mem_ready drops only while waiting for load data.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = ZERO_REG_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [INSTR_W-1:0]            mem_instr,
  input  logic [DATA_W-1:0]             mem_alu_result,
  input  logic [DATA_W-1:0]             mem_pc_plus4,
  input  logic [1:0]                    mem_wb_sel,
  input  logic                          mem_reg_write,
  input  logic [1:0]                    mem_load_size,
  input  logic                          mem_load_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]   mem_byte_off,
  input  logic [DATA_W-1:0]             dmem_rdata,
  input  logic                          dmem_rvalid,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          fwd_valid,
  output logic [REG_ADDR_W-1:0]         fwd_addr,
  output logic [DATA_W-1:0]             fwd_data,
  output logic [CNT_W-1:0]              retired_count,
  output logic                          proto_err
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  state_e                  r_state, w_next;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic                    r_reg_write;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [OFF_W-1:0]        r_off;
  logic                    r_rf_we;
  logic [REG_ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]       r_rf_wdata;
  logic [CNT_W-1:0]        r_count;
  logic                    r_proto_err;

  logic                    w_accept, w_is_load, w_ld_done, w_acc_we, w_ld_we;
  logic [REG_ADDR_W-1:0]   w_acc_rd;
  logic [DATA_W-1:0]       w_acc_data, w_load_data;
  logic                    w_unused_instr;

  assign mem_ready  = (r_state != WAIT_DATA);
  assign w_accept   = mem_valid && mem_ready;
  assign w_is_load  = (mem_wb_sel == WB_LOAD);
  assign w_acc_rd   = mem_instr[REG_ADDR_W-1:0];
  assign w_acc_data = (mem_wb_sel == WB_PC4) ? mem_pc_plus4 : mem_alu_result;
  assign w_acc_we   = mem_reg_write && (w_acc_rd != ZERO_ADDR);
  assign w_ld_done  = (r_state == WAIT_DATA) && dmem_rvalid;
  assign w_ld_we    = r_reg_write && (r_rd != ZERO_ADDR);
  assign w_unused_instr = ^mem_instr[INSTR_W-1:REG_ADDR_W];

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_rdata    (dmem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_off      (r_off),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_DATA: if (dmem_rvalid) w_next = WRITE;
      default:   w_next = w_accept ? (w_is_load ? WAIT_DATA : WRITE) : EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rf_we <= 1'b0;
      if (w_accept) begin
        r_rd        <= w_acc_rd;
        r_reg_write <= mem_reg_write;
        r_size      <= mem_load_size;
        r_unsigned  <= mem_load_unsigned;
        r_off       <= mem_byte_off;
      end
      // Write port is registered at the entry to WRITE, so address/data hold between writes.
      if (w_accept && !w_is_load) begin
        r_rf_we <= w_acc_we;
        if (w_acc_we) begin
          r_rf_waddr <= w_acc_rd;
          r_rf_wdata <= w_acc_data;
        end
      end else if (w_ld_done) begin
        r_rf_we <= w_ld_we;
        if (w_ld_we) begin
          r_rf_waddr <= r_rd;
          r_rf_wdata <= w_load_data;
        end
      end
      if (r_state == WRITE) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (dmem_rvalid && (r_state != WAIT_DATA)) r_proto_err <= 1'b1;
    end
  end

  assign rf_we         = r_rf_we;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign fwd_valid     = r_rf_we;
  assign fwd_addr      = r_rf_waddr;
  assign fwd_data      = r_rf_wdata;
  assign retired_count = r_count;
  assign proto_err     = r_proto_err;

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Parametrised write-back stage for the pipelined CPU. Holds one retiring instruction from the memory stage with a valid/ready handshake and waits a variable number of cycles for load data. Selects the result from the ALU, the aligned and extended load data, or PC+4, then writes the register file. The same write is mirrored on the forwarding bus, and retired instructions are counted.

## Interface
Parameters:
- DATA_W, 64, register/data width (32 or 64)
- INSTR_W, 32, instruction width
- REG_ADDR_W, 5, register index width; destination = instr[REG_ADDR_W-1:0]
- ZERO_REG, 31, hardwired-zero register index; never written
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  stage can accept this cycle
- mem_instr  in  INSTR_W  instruction word
- mem_alu_result  in  DATA_W  ALU result
- mem_pc_plus4  in  DATA_W  link value
- mem_wb_sel  in  2  0=ALU, 1=LOAD, 2=PC+4, 3=ALU (reserved)
- mem_reg_write  in  1  instruction writes a register
- mem_load_size  in  2  0=byte, 1=half, 2=word, 3=dword
- mem_load_unsigned  in  1  zero-extend when 1, sign-extend when 0
- mem_byte_off  in  $clog2(DATA_W/8)  byte lane of load address
- dmem_rdata  in  DATA_W  data memory read data
- dmem_rvalid  in  1  dmem_rdata valid (single-cycle pulse)
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_ADDR_W  write register
- rf_wdata  out  DATA_W  write data
- fwd_valid, fwd_addr, fwd_data  out  1/REG_ADDR_W/DATA_W  copy of rf_we/rf_waddr/rf_wdata
- retired_count  out  CNT_W  instructions retired, wrapping
- proto_err  out  1  sticky error flag: unexpected dmem_rvalid

## Operation
- FSM states: EMPTY, WAIT_DATA, WRITE. Reset state is EMPTY.
- mem_ready = (state != WAIT_DATA).
- Accept (mem_valid && mem_ready):
  - Capture the instruction, destination, wb_sel, reg_write, size, unsigned and offset.
  - For non-load, capture the selected result (ALU or PC+4) and go to WRITE.
  - For LOAD, go to WAIT_DATA.
- WAIT_DATA:
  - On dmem_rvalid, capture the extended load data and go to WRITE.
  - Otherwise stay; there is no timeout.
- WRITE:
  - rf_we = reg_write && (rd != ZERO_REG). Asserted for exactly this cycle.
  - retired_count increments by 1 whether or not a register is written.
  - If an accept occurs in the same cycle, go to EMPTY-successor state (WRITE or WAIT_DATA); otherwise go to EMPTY.
- Load extension:
  - Shift dmem_rdata right by 8*byte_off.
  - Keep 8/16/32/64 bits according to size.
  - Sign- or zero-extend the kept bits to DATA_W.
  - A size wider than DATA_W passes the full width.
  - Bytes shifted past the top read as 0, so a misaligned load is neither wrapped nor flagged.
- dmem_rvalid outside WAIT_DATA is ignored and sets proto_err. proto_err is cleared only by reset.
- rf_waddr/rf_wdata hold their last written values when rf_we=0.
- The fwd_* outputs are identical to the rf_* outputs in every cycle.

## Timing
- Non-load accepted in cycle N → rf_we in cycle N+1.
- Load accepted in N with dmem_rvalid in N+k (k≥1) → rf_we in N+k+1.
- Throughput is 1 instruction/cycle for back-to-back non-loads; mem_ready stays high.
- dmem_rvalid in the accept cycle itself is not for this load: it is ignored and flagged.
- All outputs are registered or decoded from registered state; there is no combinational path from mem_* to rf_*.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, fwd_*=0, retired_count=0, proto_err=0.
- mem_ready=1 during and immediately after reset.
- Reset asserted mid-load discards the pending instruction; a later dmem_rvalid in EMPTY sets proto_err.
- retired_count wraps from 2^CNT_W-1 to 0.

## Structure
- Package wb_pkg holds:
  - the wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4)
  - the load_size_e enum
  - the state enum (EMPTY, WAIT_DATA, WRITE)
  - ZERO_REG_DEFAULT
- Sub-module load_extend: combinational aligner/extender, parametrised by DATA_W. Inputs are rdata, size, unsigned and off; output is extended data.
- FSM, capture registers and the counter live in write_back_stage.

## Test plan
- Non-load:
  - Stimulus: ALU op, alu_result=0x1234, instr[4:0]=3, reg_write=1, accepted in cycle 10.
  - Required: rf_we=1, waddr=3, wdata=0x1234 in cycle 11; retired_count=1.
- Signed byte load:
  - Stimulus: size=0, unsigned=0, off=5, rdata=0x0000_80AB_0000_0000; rvalid 3 cycles after accept.
  - Required: wdata=0xFFFF_FFFF_FFFF_FF80; mem_ready low for those 3 cycles.
- Half load, zero vs sign extension:
  - Stimulus: size=1, off=0, rdata low half 0xBEEF.
  - Required: unsigned=1 gives wdata=0xBEEF; unsigned=0 gives wdata=0xFFFF_FFFF_FFFF_BEEF.
- Zero register:
  - Stimulus: destination 31 with reg_write=1.
  - Required: rf_we stays 0; retired_count still increments.
- Back-to-back non-loads and wrap:
  - Stimulus: 4 consecutive non-loads.
  - Required: rf_we high for 4 consecutive cycles with matching data; fwd_* equals rf_* throughout.
  - Stimulus: CNT_W=4, 16 retirements.
  - Required: retired_count wraps to 0.
- Spurious response and reset:
  - Stimulus: dmem_rvalid in EMPTY.
  - Required: proto_err=1 and it persists.
  - Stimulus: reset asserted in WAIT_DATA.
  - Required: all outputs reach their reset values immediately (asynchronous), with no rf_we.
